// File: rtl/decode_sequencer.sv
// Registered IITB-RISC decode stage: turns the accepted IR into the ID/EX control
// bundle and expands LM/SM into one micro-op per set bit of the register list.
module decode_sequencer #(
  parameter int NREG     = 8,
  parameter int RIDX_W   = $clog2(NREG),  // derived from NREG; leave at default
  parameter int OFF_W    = 16,
  parameter bit EN_MULTI = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       ir_in,
  input  logic              ir_valid,
  output logic              ir_ready,
  input  logic              stall_in,
  input  logic              flush,
  output logic              valid_out,
  output logic              regwrite,
  output logic              memtoreg,
  output logic              memread,
  output logic              memwrite,
  output logic              branch,
  output logic              regdest,
  output logic              lhi_reg,
  output logic [3:0]        aluop,
  output logic [1:0]        alusrc,
  output logic [1:0]        irlast,
  output logic [2:0]        base_reg,
  output logic [RIDX_W-1:0] mop_reg,
  output logic [OFF_W-1:0]  mop_off,
  output logic              mop_first,
  output logic              mop_last
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  typedef enum logic {S_IDLE, S_MULTI} state_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       regdest;
    logic       lhi_reg;
    logic [1:0] alusrc;
  } ctl_t;

  state_t              r_state;
  logic [NREG-1:0]     r_pend;
  ctl_t                r_ctl;
  logic                r_valid;
  logic [3:0]          r_aluop;
  logic [1:0]          r_irlast;
  logic [2:0]          r_base;
  logic [RIDX_W-1:0]   r_mop_reg;
  logic [OFF_W-1:0]    r_mop_off;
  logic                r_mop_first;
  logic                r_mop_last;

  logic [3:0]          w_opc;
  logic                w_accept;
  logic                w_is_multi;
  logic [NREG-1:0]     w_list;
  logic [NREG-1:0]     w_rest;
  logic [RIDX_W-1:0]   w_lsb;
  ctl_t                w_ctl;
  logic                w_unused;

  function automatic logic [RIDX_W-1:0] f_lowest(input logic [NREG-1:0] l);
    f_lowest = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (l[i]) f_lowest = RIDX_W'(i);
    end
  endfunction

  // Reset gates ir_ready because the IDLE state alone would otherwise advertise it.
  assign ir_ready = rst_n & (r_state == S_IDLE) & ~stall_in & ~flush;
  assign w_unused = ^ir_in;

  always_comb begin
    w_opc      = ir_in[15:12];
    w_accept   = ir_valid & ir_ready;
    w_is_multi = EN_MULTI && ((w_opc == OP_LM) || (w_opc == OP_SM));
    w_list     = (r_state == S_MULTI) ? r_pend : ir_in[NREG-1:0];
    // Clearing the lowest set bit needs no index: x & (x-1).
    w_rest     = w_list & (w_list - NREG'(1));
    w_lsb      = f_lowest(w_list);
    w_ctl      = '0;
    case (w_opc)
      OP_ADD, OP_NDU: w_ctl.regwrite = 1'b1;
      OP_ADI: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.regdest  = 1'b1;
        w_ctl.alusrc   = 2'b10;
      end
      OP_LHI: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.lhi_reg  = 1'b1;
      end
      OP_LW: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.memread  = 1'b1;
        w_ctl.memtoreg = 1'b1;
        w_ctl.regdest  = 1'b1;
        w_ctl.alusrc   = 2'b10;
      end
      OP_SW: begin
        w_ctl.memwrite = 1'b1;
        w_ctl.alusrc   = 2'b10;
      end
      OP_LM: if (EN_MULTI) begin
        w_ctl.regwrite = 1'b1;
        w_ctl.memread  = 1'b1;
        w_ctl.memtoreg = 1'b1;
        w_ctl.alusrc   = 2'b11;
      end
      OP_SM: if (EN_MULTI) begin
        w_ctl.memwrite = 1'b1;
        w_ctl.alusrc   = 2'b11;
      end
      OP_BEQ: w_ctl.branch = 1'b1;
      OP_JAL, OP_JLR: begin
        w_ctl.regwrite = 1'b1;
        w_ctl.branch   = 1'b1;
      end
      default: w_ctl = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_ctl       <= '0;
      r_valid     <= 1'b0;
      r_aluop     <= '0;
      r_irlast    <= '0;
      r_base      <= '0;
      r_mop_reg   <= '0;
      r_mop_off   <= '0;
      r_mop_first <= 1'b0;
      r_mop_last  <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_ctl       <= '0;
      r_valid     <= 1'b0;
      r_mop_reg   <= '0;
      r_mop_off   <= '0;
      r_mop_first <= 1'b0;
      r_mop_last  <= 1'b0;
    end else if (!stall_in) begin
      case (r_state)
        S_IDLE: begin
          r_mop_reg   <= '0;
          r_mop_off   <= '0;
          r_mop_first <= 1'b0;
          r_mop_last  <= 1'b0;
          if (w_accept) begin
            r_valid  <= 1'b1;
            r_aluop  <= w_opc;
            r_irlast <= ir_in[1:0];
            r_base   <= ir_in[11:9];
            r_ctl    <= w_ctl;
            if (w_is_multi) begin
              r_mop_first <= 1'b1;
              if (w_list == '0) begin
                r_ctl      <= '0;
                r_mop_last <= 1'b1;
              end else begin
                r_mop_reg  <= w_lsb;
                r_mop_last <= (w_rest == '0);
                r_pend     <= w_rest;
                if (w_rest != '0) r_state <= S_MULTI;
              end
            end
          end else begin
            r_valid <= 1'b0;
            r_ctl   <= '0;
          end
        end
        S_MULTI: begin
          r_mop_reg   <= w_lsb;
          r_mop_off   <= r_mop_off + OFF_W'(1);
          r_mop_first <= 1'b0;
          r_mop_last  <= (w_rest == '0);
          r_pend      <= w_rest;
          if (w_rest == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_out = r_valid;
  assign regwrite  = r_ctl.regwrite;
  assign memtoreg  = r_ctl.memtoreg;
  assign memread   = r_ctl.memread;
  assign memwrite  = r_ctl.memwrite;
  assign branch    = r_ctl.branch;
  assign regdest   = r_ctl.regdest;
  assign lhi_reg   = r_ctl.lhi_reg;
  assign alusrc    = r_ctl.alusrc;
  assign aluop     = r_aluop;
  assign irlast    = r_irlast;
  assign base_reg  = r_base;
  assign mop_reg   = r_mop_reg;
  assign mop_off   = r_mop_off;
  assign mop_first = r_mop_first;
  assign mop_last  = r_mop_last;

endmodule

// File: doc/decode_sequencer.md
Name: decode_sequencer

Overview:
- Registered decode stage for the IITB-RISC pipeline; replaces the purely combinational opcode decoder.
- Decodes the fetched IR into the ID/EX control bundle one clock after acceptance.
- Expands LM/SM (load/store multiple) into one micro-op per set bit of the register list, holding off fetch via ir_ready until expansion completes.
- Supports downstream stall and pipeline flush.

Parameters:
- NREG, 8, width of the LM/SM register list (IR[NREG-1:0]); legal range 2..9.
- RIDX_W, $clog2(NREG), width of the micro-op register index (derived; do not override).
- OFF_W, 16, width of the micro-op word offset.
- EN_MULTI, 1, 1 = LM/SM expanded; 0 = LM/SM decode as a NOP.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ir_in  in  16  instruction from IF/ID
- ir_valid  in  1  ir_in holds a real instruction
- ir_ready  out  1  decoder accepts ir_in this cycle (combinational)
- stall_in  in  1  downstream stall; hold all state and outputs
- flush  in  1  synchronous kill of the current and pending decode
- valid_out  out  1  control bundle is valid
- regwrite, memtoreg, memread, memwrite, branch, regdest, lhi_reg  out  1 each  control bits
- aluop  out  4  opcode (IR[15:12]) of the accepted instruction
- alusrc  out  2  00 reg, 10 imm, 11 micro-op offset
- irlast  out  2  IR[1:0] (condition bits)
- base_reg  out  3  IR[11:9] of the accepted instruction
- mop_reg  out  RIDX_W  register index of the current LM/SM micro-op
- mop_off  out  OFF_W  word offset of the current micro-op (0,1,2,...)
- mop_first, mop_last  out  1 each  first/last micro-op of an expansion

Behaviour:
- Reset (rst_n=0, asynchronous): every output register is 0, state is IDLE, and the pending list is 0. ir_ready is 0 while in reset.
- ir_ready = (state==IDLE) & ~stall_in & ~flush. An instruction is accepted when ir_valid & ir_ready.
- Priority at each edge: reset, then flush, then stall_in, then normal operation.
- flush: valid_out and all control bits go to 0, state goes to IDLE, the pending list is cleared, and ir_in is not accepted. flush wins over stall_in.
- stall_in=1 without flush: outputs, state, list and offset hold.
- IDLE with no acceptance: valid_out goes to 0 and all write/mem controls go to 0 (bubble).
- Single-cycle opcodes (latency 1 edge after acceptance; valid_out=1):
  - 0000 ADD, 0010 NDU: regwrite, alusrc=00, regdest=0.
  - 0001 ADI: regwrite, alusrc=10, regdest=1.
  - 0011 LHI: regwrite, lhi_reg=1.
  - 0100 LW: regwrite, memread, memtoreg, alusrc=10, regdest=1.
  - 0101 SW: memwrite, alusrc=10.
  - 1100 BEQ: branch, alusrc=00.
  - 1000 JAL, 1001 JLR: regwrite, branch.
  - Other opcodes: valid_out=1 with all controls 0.
  - aluop, irlast and base_reg always come from the accepted IR. mop_* are 0 for these opcodes.
- LM (0110) / SM (0111) with EN_MULTI=1; L = IR[NREG-1:0]:
  - L==0: emit one NOP (valid_out=1, controls 0, mop_first=mop_last=1); state stays IDLE.
  - L!=0, acceptance edge: emit the micro-op for the lowest set bit b. mop_reg=b, mop_off=0, mop_first=1. Pending list P = L with bit b cleared. mop_last=(P==0). If P!=0, state goes to MULTI.
  - MULTI, each non-stalled edge: emit the micro-op for the lowest set bit of P, clear that bit, increment mop_off by 1 (wraps at OFF_W), mop_first=0. When the new P==0, set mop_last=1 and return to IDLE.
  - Result: k set bits give exactly k consecutive valid micro-ops, with ir_ready low for k-1 cycles.
  - LM micro-op controls: regwrite, memread, memtoreg, alusrc=11.
  - SM micro-op controls: memwrite, alusrc=11.
- EN_MULTI=0: LM/SM decode as a single NOP; no FSM entry.
- Reset or flush mid-expansion abandons the remaining bits, with no further micro-ops.

Test Plan:
- Reset release, ir_in=16'h0001 (ADD, irlast=01), ir_valid=1: one edge later valid_out=1, regwrite=1, aluop=0000, alusrc=00, irlast=01, mop_*=0.
- LM ir_in=16'h6AA5 (base r5, list 8'hA5): 4 micro-ops, mop_reg 0,2,5,7 and mop_off 0,1,2,3. Flags: mop_first only on the first, mop_last only on the fourth. memread=regwrite=1, base_reg=5, ir_ready low for exactly 3 cycles.
- Same LM with stall_in=1 for 2 cycles after the second micro-op: outputs hold mop_reg=2/mop_off=1. Resume then gives 5, then 7; no bit is lost or duplicated.
- SM ir_in=16'h7007 with flush on the edge after the first micro-op: valid_out=0 next cycle, state IDLE, ir_ready=1. The following ADI shows alusrc=10 and regdest=1.
- LM with list 0: a single valid NOP with mop_first=mop_last=1, regwrite=memread=0, ir_ready never drops.
- rst_n asserted asynchronously mid-LM (between edges): all outputs 0 immediately. After release, no residual micro-ops.
